// File: rtl/cmp_iter.sv
// Multi-cycle MSB-first magnitude comparator, CHUNK bits per cycle.
// Define CMP_EARLY_TERM_EN to exit at the first differing chunk.
module cmp_iter #(
  parameter int WIDTH = 64,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  input  logic             sgn,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [1:0]       res,
  output logic             busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] R_GT = 2'b01;
  localparam logic [1:0] R_LT = 2'b10;
  localparam logic [1:0] R_EQ = 2'b11;

  generate
    if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
      $error("cmp_iter: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op1_q, op2_q;
  logic [WIDTH-1:0] msk;
  logic [IW-1:0]    idx_q;
  logic [1:0]       res_q;
  logic [CHUNK-1:0] c1, c2;
  logic [1:0]       cres;
  logic             ne;
  logic             last;

  // Flipping the sign bit maps two's-complement order onto unsigned order.
  always_comb begin
    msk          = '0;
    msk[WIDTH-1] = sgn;
  end

  assign c1   = op1_q[idx_q*CHUNK +: CHUNK];
  assign c2   = op2_q[idx_q*CHUNK +: CHUNK];
  assign ne   = (c1 != c2);
  assign last = (idx_q == '0);
  assign cres = ne ? ((c1 > c2) ? R_GT : R_LT) : R_EQ;

`ifndef CMP_EARLY_TERM_EN
  logic       dec_q;
  logic [1:0] dres_q;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (in_valid) state_d = CMP;
`ifdef CMP_EARLY_TERM_EN
      CMP:  if (ne || last) state_d = DONE;
`else
      CMP:  if (last) state_d = DONE;
`endif
      DONE: if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = (state_q == IDLE);
    busy      = (state_q != IDLE);
    out_valid = (state_q == DONE);
  end

  assign res = res_q;

  // Datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op1_q  <= '0;
      op2_q  <= '0;
      idx_q  <= '0;
      res_q  <= 2'b00;
`ifndef CMP_EARLY_TERM_EN
      dec_q  <= 1'b0;
      dres_q <= 2'b00;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (in_valid) begin
            op1_q  <= op1 ^ msk;
            op2_q  <= op2 ^ msk;
            idx_q  <= IW'(N - 1);
            res_q  <= 2'b00;
`ifndef CMP_EARLY_TERM_EN
            dec_q  <= 1'b0;
            dres_q <= 2'b00;
`endif
          end
        end
        CMP: begin
          if (!last) idx_q <= idx_q - 1'b1;
`ifdef CMP_EARLY_TERM_EN
          if (ne || last) res_q <= cres;
`else
          // Sticky: the most significant differing chunk wins.
          if (!dec_q && ne) begin
            dec_q  <= 1'b1;
            dres_q <= cres;
          end
          if (last) res_q <= dec_q ? dres_q : cres;
`endif
        end
        DONE: if (out_ready) res_q <= 2'b00;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_iter.sv
// Directed bench for cmp_iter (WIDTH=64, CHUNK=8).
// Expected latencies follow CMP_EARLY_TERM_EN.
module tb_cmp_iter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] op1 = '0;
  logic [63:0] op2 = '0;
  logic        sgn = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [1:0]  res;
  logic        busy;

  int chk = 0;
  int err = 0;

`ifdef CMP_EARLY_TERM_EN
  localparam int LE = 1;
`else
  localparam int LE = 8;
`endif

  cmp_iter #(.WIDTH(64), .CHUNK(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .op1(op1), .op2(op2), .sgn(sgn),
    .out_valid(out_valid), .out_ready(out_ready),
    .res(res), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic s);
    op1 = a; op2 = b; sgn = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    op1 = '1; op2 = '0; sgn = ~s;
  endtask

  task automatic wait_out(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    chk++;
    if ({in_ready, out_valid, res, busy} !== 5'b10000) begin
      err++;
      $display("FAIL reset got rdy=%b ov=%b res=%b busy=%b want 1 0 00 0",
               in_ready, out_valid, res, busy);
    end
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_unsigned();
    int n;
    send(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0);
    chk++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      err++;
      $display("FAIL u_busy got busy=%b rdy=%b want 1 0", busy, in_ready);
    end
    wait_out(n);
    chk++;
    if (n !== LE) begin
      err++; $display("FAIL u_lat got %0d want %0d", n, LE);
    end
    chk++;
    if (res !== 2'b01) begin
      err++; $display("FAIL u_res got %b want 01", res);
    end
    release_out();
    chk++;
    if ({out_valid, res, in_ready, busy} !== 5'b00010) begin
      err++;
      $display("FAIL u_hs got ov=%b res=%b rdy=%b busy=%b want 0 00 1 0",
               out_valid, res, in_ready, busy);
    end
  endtask

  task automatic test_signed();
    int n;
    send(64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    wait_out(n);
    chk++;
    if (n !== LE) begin
      err++; $display("FAIL s_lat got %0d want %0d", n, LE);
    end
    chk++;
    if (res !== 2'b10) begin
      err++; $display("FAIL s_res got %b want 10", res);
    end
    release_out();
    send(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0001, 1'b1);
    wait_out(n);
    chk++;
    if (n !== LE) begin
      err++; $display("FAIL s_m1_lat got %0d want %0d", n, LE);
    end
    chk++;
    if (res !== 2'b10) begin
      err++; $display("FAIL s_m1_res got %b want 10", res);
    end
    release_out();
  endtask

  task automatic test_equal();
    int n;
    send(64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 1'b0);
    wait_out(n);
    chk++;
    if (n !== 8) begin
      err++; $display("FAIL eq_lat got %0d want 8", n);
    end
    chk++;
    if (res !== 2'b11) begin
      err++; $display("FAIL eq_res got %b want 11", res);
    end
    release_out();
    chk++;
    if ({out_valid, res} !== 3'b000) begin
      err++; $display("FAIL eq_hs got ov=%b res=%b want 0 00", out_valid, res);
    end
  endtask

  task automatic test_lsb();
    int n;
    send(64'h0000_0000_0000_0001, 64'h0, 1'b0);
    wait_out(n);
    chk++;
    if (n !== 8) begin
      err++; $display("FAIL lsb_lat got %0d want 8", n);
    end
    chk++;
    if (res !== 2'b01) begin
      err++; $display("FAIL lsb_res got %b want 01", res);
    end
    release_out();
    send(64'h0100_0000_0000_0000, 64'h0, 1'b0);
    wait_out(n);
    chk++;
    if (n !== LE) begin
      err++; $display("FAIL msb_lat got %0d want %0d", n, LE);
    end
    chk++;
    if (res !== 2'b01) begin
      err++; $display("FAIL msb_res got %b want 01", res);
    end
    release_out();
  endtask

  task automatic test_backpressure();
    int n;
    send(64'd5, 64'd3, 1'b0);
    wait_out(n);
    chk++;
    if (n !== 8 || res !== 2'b01) begin
      err++; $display("FAIL bp_first got lat=%0d res=%b want 8 01", n, res);
    end
    for (int i = 0; i < 5; i++) begin
      op1 = 64'd0; op2 = 64'hFF; sgn = 1'b0; in_valid = 1'b1;
      @(posedge clk); #1;
      chk++;
      if ({out_valid, res, in_ready} !== 4'b1010) begin
        err++;
        $display("FAIL bp_hold%0d got ov=%b res=%b rdy=%b want 1 01 0",
                 i, out_valid, res, in_ready);
      end
    end
    in_valid = 1'b0;
    release_out();
    chk++;
    if ({out_valid, res, in_ready} !== 4'b0001) begin
      err++;
      $display("FAIL bp_rel got ov=%b res=%b rdy=%b want 0 00 1",
               out_valid, res, in_ready);
    end
    @(posedge clk); #1;
    chk++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      err++;
      $display("FAIL bp_ignored got busy=%b ov=%b want 0 0", busy, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    send(64'hA5A5_A5A5_A5A5_A5A5, 64'hA5A5_A5A5_A5A5_A5A5, 1'b0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      err++; $display("FAIL rm_pre got busy=%b ov=%b want 1 0", busy, out_valid);
    end
    rst = 1'b1;
    #1;
    chk++;
    if ({out_valid, res, busy, in_ready} !== 5'b00001) begin
      err++;
      $display("FAIL rm_rst got ov=%b res=%b busy=%b rdy=%b want 0 00 0 1",
               out_valid, res, busy, in_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    send(64'd5, 64'd3, 1'b0);
    wait_out(n);
    chk++;
    if (n !== 8 || res !== 2'b01) begin
      err++; $display("FAIL rm_next got lat=%0d res=%b want 8 01", n, res);
    end
    release_out();
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_equal();
    test_lsb();
    test_backpressure();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", err, chk);
    $finish;
  end

endmodule
